pu_msp430_dbg_hwbrk_ctrl: RTL and testbench
===========================================

# pu_msp430_dbg_hwbrk_ctrl

Debug-side controller for the hardware breakpoint units. It decodes debug register accesses into per-unit register selects and muxes their read data. It arbitrates simultaneous break events from up to four units, records the winning cause, and runs the halt request/acknowledge handshake toward the CPU. Optionally it sequences the units as a chained trigger, so that unit n+1 only breaks after unit n has hit. It sits between the debug register interface and the array of breakpoint units.

## Interface
- NUM_BRK, 4, number of breakpoint units attached; legal range 1..4.
- dbg_clk  in  1  debug clock; all state on rising edge.
- dbg_rst  in  1  reset, asynchronous, active-high.
- dbg_addr  in  6  debug register address.
- dbg_rd  in  1  register read strobe.
- dbg_wr  in  1  register write strobe.
- dbg_din  in  16  register write data.
- unit_halt  in  NUM_BRK  per-unit break command (brk_halt of each unit).
- unit_pnd  in  NUM_BRK  per-unit break/watch pending.
- unit_dout  in  16*NUM_BRK  per-unit read data; unit n at bits [16n+15:16n].
- cpu_halted  in  1  CPU halted status (acknowledge).
- unit_reg_rd  out  4*NUM_BRK  per-unit register read selects; unit n at [4n+3:4n] (CTL, STAT, ADDR0, ADDR1).
- unit_reg_wr  out  4*NUM_BRK  per-unit register write selects, same packing.
- ctrl_dout  out  16  read data to debug interface.
- halt_req  out  1  registered halt request to CPU.
- brk_pnd  out  1  OR of unit_pnd and seq hit mask.

## Operation
- Address map:
  - 0x07 is BRK_SEQ, owned by this block.
  - Unit n register k sits at 0x08+4n+k.
  - Addresses for n ≥ NUM_BRK and all other addresses select nothing and read 0.
- unit_reg_rd/wr decode:
  - The one-hot select equals dbg_rd/dbg_wr AND'ed with the address match. Combinational.
- ctrl_dout: combinational mux of the selected unit_dout or BRK_SEQ; 0 when dbg_rd=0.
- BRK_SEQ fields:
  - [0] CHAIN_ON (R/W).
  - [1] ABORT (write-only, reads 0).
  - [3:2] STAGE (RO).
  - [7:4] HIT mask (sticky, write-1-to-clear).
  - [9:8] CAUSE (RO).
  - [10] CAUSE_VLD (RO, cleared by writing 1).
  - [15:11] read 0.
- Qualified hit:
  - CHAIN_ON=0: any unit_halt.
  - CHAIN_ON=1: unit_halt[STAGE] only.
- Chain stage advance:
  - A hit on STAGE < NUM_BRK-1 increments STAGE; no halt is issued.
  - A hit on STAGE = NUM_BRK-1 issues a halt and STAGE returns to 0.
- Halt FSM:
  - IDLE: a qualified halting hit goes to REQ, sets halt_req, latches CAUSE (lowest index wins), and sets CAUSE_VLD.
  - REQ: cpu_halted=1 goes to HALTED and drops halt_req. A BRK_SEQ write with ABORT=1 goes to IDLE and drops halt_req.
  - HALTED: cpu_halted=0 (CPU resumed) goes to IDLE.
- HIT mask: every raw unit_halt sets its bit in any state and any mode.
- Hits while in REQ or HALTED do not update CAUSE and do not advance STAGE.

## Timing
- Reset values:
  - halt_req=0, FSM=IDLE, BRK_SEQ=0.
  - unit_reg_rd/wr=0 and ctrl_dout=0 (strobes low).
- halt_req rises one cycle after the qualifying unit_halt cycle.
- halt_req falls the cycle after cpu_halted is sampled 1.
- Register selects and read data have zero latency (combinational); BRK_SEQ writes take effect on the next edge.
- Simultaneous events:
  - A hit and a W1C on the same HIT bit in the same cycle: the set wins.
  - A CHAIN_ON write and a hit in the same cycle: the hit is evaluated with the old CHAIN_ON and STAGE, then the write forces STAGE=0.
  - ABORT and cpu_halted=1 in the same cycle while in REQ: ABORT wins (IDLE).
- If cpu_halted is already 1 at hit time, the FSM still passes through REQ for exactly one cycle.
- Reset mid-handshake returns to IDLE with halt_req=0 immediately (asynchronous).

## Configuration
- HWBRK_CHAIN_EN defined: chained sequencing as above.
- HWBRK_CHAIN_EN undefined:
  - CHAIN_ON reads 0 and writes to it are ignored.
  - STAGE is held at 0.
  - Every unit_halt is a qualified halting hit.

## Test plan
- NUM_BRK=4. Write 0x0005 at 0x0D → unit_reg_wr[5]=1 for one cycle; read 0x0D with unit_dout[31:16]=0xBEEF → ctrl_dout=0xBEEF. Read 0x18 → 0.
- unit_halt=4'b1010 for one cycle, cpu_halted=0 → halt_req=1 next cycle; BRK_SEQ reads CAUSE=1, CAUSE_VLD=1, HIT=0xA. Raise cpu_halted → halt_req=0 next cycle; drop it → IDLE.
- HWBRK_CHAIN_EN, CHAIN_ON=1, then pulse unit_halt in order 2, 0, 1, 2, 3 → first pulse (unit 2) gives no halt (STAGE stays 0); STAGE reaches 3; halt_req only after unit 3; then STAGE=0 and CAUSE=3.
- In REQ, write BRK_SEQ=0x0002 (ABORT) in the same cycle cpu_halted rises → next state IDLE, halt_req=0.
- Write 0x00F0 to BRK_SEQ in the same cycle unit_halt[0]=1 → HIT=0x1 afterward.
- Assert dbg_rst while in REQ → halt_req=0 immediately; BRK_SEQ=0 after release.

Source files
------------

// File: rtl/pu_msp430_dbg_hwbrk_ctrl.sv
// pu_msp430_dbg_hwbrk_ctrl
// Debug-side controller for the hardware breakpoint units:
//   - decodes debug register accesses into per-unit read/write selects,
//   - muxes unit read data and the local BRK_SEQ register,
//   - arbitrates break events, records the cause and runs the halt handshake.
// Optional feature macro: HWBRK_CHAIN_EN (chained trigger sequencing).
// When it is undefined, CHAIN_ON reads 0, STAGE stays 0 and every unit_halt
// is a halting hit.
module pu_msp430_dbg_hwbrk_ctrl #(
    parameter int NUM_BRK = 4
) (
    input  logic                 dbg_clk,
    input  logic                 dbg_rst,
    input  logic [5:0]           dbg_addr,
    input  logic                 dbg_rd,
    input  logic                 dbg_wr,
    input  logic [15:0]          dbg_din,
    input  logic [NUM_BRK-1:0]   unit_halt,
    input  logic [NUM_BRK-1:0]   unit_pnd,
    input  logic [16*NUM_BRK-1:0] unit_dout,
    input  logic                 cpu_halted,
    output logic [4*NUM_BRK-1:0] unit_reg_rd,
    output logic [4*NUM_BRK-1:0] unit_reg_wr,
    output logic [15:0]          ctrl_dout,
    output logic                 halt_req,
    output logic                 brk_pnd
);

    localparam logic [5:0] SEQ_ADDR   = 6'h07;
    localparam logic [1:0] LAST_STAGE = 2'(NUM_BRK - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [3:0]  halt_vec;
    logic [3:0]  hit_reg;
    logic [1:0]  cause_reg;
    logic        cause_vld_reg;
    logic        chain_on;
    logic [1:0]  stage;
    logic        seq_wr;
    logic        abort;
    logic        halt_hit;
    logic [1:0]  hit_cause;
    logic [15:0] seq_rdata;
    logic        unused_din;

    // Data bits that carry no meaning in BRK_SEQ (bit 0 is ignored when chaining is compiled out).
    assign unused_din = ^{dbg_din[15:11], dbg_din[9:8], dbg_din[3:2], dbg_din[0]};

    assign seq_wr = dbg_wr & (dbg_addr == SEQ_ADDR);
    assign abort  = seq_wr & dbg_din[1];

    // Widen the unit break vector to the fixed 4-slot register layout.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_halt_vec
            if (gi < NUM_BRK) begin : g_present
                assign halt_vec[gi] = unit_halt[gi];
            end else begin : g_absent
                assign halt_vec[gi] = 1'b0;
            end
        end
    endgenerate

    // One-hot register selects: unit n register k lives at 0x08 + 4n + k.
    genvar gk;
    generate
        for (gi = 0; gi < NUM_BRK; gi++) begin : g_unit
            for (gk = 0; gk < 4; gk++) begin : g_reg
                localparam logic [5:0] REG_ADDR = 6'(8 + 4 * gi + gk);
                assign unit_reg_rd[4*gi+gk] = dbg_rd & (dbg_addr == REG_ADDR);
                assign unit_reg_wr[4*gi+gk] = dbg_wr & (dbg_addr == REG_ADDR);
            end
        end
    endgenerate

    assign seq_rdata = {5'b0, cause_vld_reg, cause_reg, hit_reg, stage, 1'b0, chain_on};

    // Read data mux; quiet (zero) whenever no read strobe is present.
    always_comb begin
        ctrl_dout = 16'h0000;
        if (dbg_rd) begin
            if (dbg_addr == SEQ_ADDR) begin
                ctrl_dout = seq_rdata;
            end
            for (int i = 0; i < NUM_BRK; i++) begin
                if (dbg_addr[5:2] == 4'(2 + i)) begin
                    ctrl_dout = unit_dout[16*i +: 16];
                end
            end
        end
    end

    assign brk_pnd = (|unit_pnd) | (|hit_reg);

`ifdef HWBRK_CHAIN_EN
    logic       chain_on_reg;
    logic [1:0] stage_reg;

    // Chain sequencing: advance on the current stage's unit, any BRK_SEQ write restarts.
    always_ff @(posedge dbg_clk or posedge dbg_rst) begin
        if (dbg_rst) begin
            chain_on_reg <= 1'b0;
            stage_reg    <= 2'd0;
        end else begin
            if (seq_wr) begin
                chain_on_reg <= dbg_din[0];
                stage_reg    <= 2'd0;
            end else if ((state_reg == ST_IDLE) && chain_on_reg && halt_vec[stage_reg]) begin
                stage_reg <= (stage_reg == LAST_STAGE) ? 2'd0 : stage_reg + 2'd1;
            end
        end
    end

    assign chain_on = chain_on_reg;
    assign stage    = stage_reg;
`else
    assign chain_on = 1'b0;
    assign stage    = 2'd0;
`endif

    // Qualify break events and pick the cause (lowest index wins when unchained).
    always_comb begin
        halt_hit  = 1'b0;
        hit_cause = 2'd0;
        if (chain_on) begin
            halt_hit  = halt_vec[stage] && (stage == LAST_STAGE);
            hit_cause = stage;
        end else begin
            halt_hit = |halt_vec;
            for (int i = 3; i >= 0; i--) begin
                if (halt_vec[i]) begin
                    hit_cause = 2'(i);
                end
            end
        end
    end

    // Sticky HIT mask (set beats clear) and break cause capture.
    always_ff @(posedge dbg_clk or posedge dbg_rst) begin
        if (dbg_rst) begin
            hit_reg       <= 4'h0;
            cause_reg     <= 2'd0;
            cause_vld_reg <= 1'b0;
        end else begin
            hit_reg <= (seq_wr ? (hit_reg & ~dbg_din[7:4]) : hit_reg) | halt_vec;
            if ((state_reg == ST_IDLE) && halt_hit) begin
                cause_reg     <= hit_cause;
                cause_vld_reg <= 1'b1;
            end else if (seq_wr && dbg_din[10]) begin
                cause_vld_reg <= 1'b0;
            end
        end
    end

    // Halt FSM state register.
    always_ff @(posedge dbg_clk or posedge dbg_rst) begin
        if (dbg_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Halt FSM next state; abort takes priority over the CPU acknowledge.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (halt_hit) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (cpu_halted) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!cpu_halted) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Halt FSM output: request is a direct decode of the registered state.
    always_comb begin
        halt_req = (state_reg == ST_REQ);
    end

endmodule

// File: tb/tb_pu_msp430_dbg_hwbrk_ctrl.sv
// Directed testbench for pu_msp430_dbg_hwbrk_ctrl (NUM_BRK = 4).
module tb_pu_msp430_dbg_hwbrk_ctrl;

    logic        dbg_clk;
    logic        dbg_rst;
    logic [5:0]  dbg_addr;
    logic        dbg_rd;
    logic        dbg_wr;
    logic [15:0] dbg_din;
    logic [3:0]  unit_halt;
    logic [3:0]  unit_pnd;
    logic [63:0] unit_dout;
    logic        cpu_halted;
    logic [15:0] unit_reg_rd;
    logic [15:0] unit_reg_wr;
    logic [15:0] ctrl_dout;
    logic        halt_req;
    logic        brk_pnd;

    int cmp_cnt;
    int err_cnt;

    pu_msp430_dbg_hwbrk_ctrl #(.NUM_BRK(4)) dut (
        .dbg_clk     (dbg_clk),
        .dbg_rst     (dbg_rst),
        .dbg_addr    (dbg_addr),
        .dbg_rd      (dbg_rd),
        .dbg_wr      (dbg_wr),
        .dbg_din     (dbg_din),
        .unit_halt   (unit_halt),
        .unit_pnd    (unit_pnd),
        .unit_dout   (unit_dout),
        .cpu_halted  (cpu_halted),
        .unit_reg_rd (unit_reg_rd),
        .unit_reg_wr (unit_reg_wr),
        .ctrl_dout   (ctrl_dout),
        .halt_req    (halt_req),
        .brk_pnd     (brk_pnd)
    );

    initial dbg_clk = 1'b0;
    always #5 dbg_clk = ~dbg_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
        $display("check %-14s observed 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge dbg_clk);
        #1;
    endtask

    task automatic reg_write(input logic [5:0] a, input logic [15:0] d);
        dbg_addr = a;
        dbg_din  = d;
        dbg_wr   = 1'b1;
        tick();
        dbg_wr   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [5:0] a, input logic [15:0] exp);
        dbg_addr = a;
        dbg_rd   = 1'b1;
        #1;
        check(tag, ctrl_dout, exp);
        dbg_rd   = 1'b0;
        #1;
    endtask

    task automatic pulse_halt(input logic [3:0] v);
        unit_halt = v;
        tick();
        unit_halt = 4'h0;
    endtask

    initial begin
        cmp_cnt    = 0;
        err_cnt    = 0;
        dbg_rst    = 1'b1;
        dbg_addr   = 6'h00;
        dbg_rd     = 1'b0;
        dbg_wr     = 1'b0;
        dbg_din    = 16'h0000;
        unit_halt  = 4'h0;
        unit_pnd   = 4'h0;
        unit_dout  = {16'h4444, 16'h3333, 16'hBEEF, 16'h1111};
        cpu_halted = 1'b0;

        // Reset state
        #2;
        check("rst_halt_req", {15'b0, halt_req}, 16'h0000);
        check("rst_dout", ctrl_dout, 16'h0000);
        check("rst_reg_rd", unit_reg_rd, 16'h0000);
        check("rst_reg_wr", unit_reg_wr, 16'h0000);
        tick();
        tick();
        dbg_rst = 1'b0;
        read_check("rst_seq", 6'h07, 16'h0000);

        // Register decode and read mux
        dbg_addr = 6'h0D;
        dbg_din  = 16'h0005;
        dbg_wr   = 1'b1;
        #1;
        check("wr_sel_0d", unit_reg_wr, 16'h0020);
        tick();
        dbg_wr = 1'b0;
        #1;
        check("wr_sel_idle", unit_reg_wr, 16'h0000);
        dbg_addr = 6'h0D;
        dbg_rd   = 1'b1;
        #1;
        check("rd_sel_0d", unit_reg_rd, 16'h0020);
        check("rd_data_0d", ctrl_dout, 16'hBEEF);
        dbg_addr = 6'h14;
        #1;
        check("rd_sel_14", unit_reg_rd, 16'h1000);
        check("rd_data_14", ctrl_dout, 16'h4444);
        dbg_addr = 6'h18;
        #1;
        check("rd_sel_18", unit_reg_rd, 16'h0000);
        check("rd_data_18", ctrl_dout, 16'h0000);
        dbg_rd = 1'b0;
        dbg_addr = 6'h0D;
        #1;
        check("rd_strobe_low", ctrl_dout, 16'h0000);

`ifdef HWBRK_CHAIN_EN
        // Chained sequencing: 2 (ignored), 0, 1, 2, 3 -> halt on 3
        reg_write(6'h07, 16'h0001);
        read_check("chain_on", 6'h07, 16'h0001);
        pulse_halt(4'b0100);
        check("ch_u2_noreq", {15'b0, halt_req}, 16'h0000);
        read_check("ch_u2_seq", 6'h07, 16'h0041);
        pulse_halt(4'b0001);
        read_check("ch_u0_seq", 6'h07, 16'h0055);
        pulse_halt(4'b0010);
        read_check("ch_u1_seq", 6'h07, 16'h0079);
        pulse_halt(4'b0100);
        check("ch_u2b_noreq", {15'b0, halt_req}, 16'h0000);
        read_check("ch_u2b_seq", 6'h07, 16'h007D);
        pulse_halt(4'b1000);
        check("ch_u3_req", {15'b0, halt_req}, 16'h0001);
        read_check("ch_u3_seq", 6'h07, 16'h07F1);
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
        tick();
        reg_write(6'h07, 16'h04F0);
        read_check("ch_cleared", 6'h07, 16'h0000);
`endif

        // Basic halt: units 1 and 3 together, lowest index wins
        pulse_halt(4'b1010);
        check("hit_req", {15'b0, halt_req}, 16'h0001);
        read_check("hit_seq", 6'h07, 16'h05A0);
        check("hit_pnd", {15'b0, brk_pnd}, 16'h0001);
        cpu_halted = 1'b1;
        tick();
        check("ack_drop", {15'b0, halt_req}, 16'h0000);
        pulse_halt(4'b0001);
        check("halted_noreq", {15'b0, halt_req}, 16'h0000);
        read_check("halted_seq", 6'h07, 16'h05B0);
        cpu_halted = 1'b0;
        tick();
        check("resume_idle", {15'b0, halt_req}, 16'h0000);

        // New hit from IDLE, then ABORT together with cpu_halted
        pulse_halt(4'b0100);
        check("hit2_req", {15'b0, halt_req}, 16'h0001);
        read_check("hit2_seq", 6'h07, 16'h06F0);
        cpu_halted = 1'b1;
        reg_write(6'h07, 16'h0002);
        check("abort_drop", {15'b0, halt_req}, 16'h0000);
        tick();
        check("abort_stay", {15'b0, halt_req}, 16'h0000);

        // Hit while cpu_halted already 1: exactly one REQ cycle
        pulse_halt(4'b1000);
        check("prehalt_req", {15'b0, halt_req}, 16'h0001);
        tick();
        check("prehalt_1cyc", {15'b0, halt_req}, 16'h0000);
        read_check("prehalt_seq", 6'h07, 16'h07F0);
        cpu_halted = 1'b0;
        tick();

        // W1C of HIT/CAUSE_VLD in the same cycle as a unit 0 hit: set wins
        unit_halt = 4'b0001;
        reg_write(6'h07, 16'h04F0);
        unit_halt = 4'h0;
        check("w1c_req", {15'b0, halt_req}, 16'h0001);
        read_check("w1c_seq", 6'h07, 16'h0410);
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
        tick();
        reg_write(6'h07, 16'h0400);
        read_check("vld_clr", 6'h07, 16'h0010);
        check("pnd_hit", {15'b0, brk_pnd}, 16'h0001);
        reg_write(6'h07, 16'h00F0);
        read_check("hit_clr", 6'h07, 16'h0000);
        check("pnd_none", {15'b0, brk_pnd}, 16'h0000);
        unit_pnd = 4'b0100;
        #1;
        check("pnd_unit", {15'b0, brk_pnd}, 16'h0001);
        unit_pnd = 4'h0;

`ifndef HWBRK_CHAIN_EN
        // CHAIN_ON is not writable without chaining support
        reg_write(6'h07, 16'h0001);
        read_check("chain_ro", 6'h07, 16'h0000);
`endif

        // Asynchronous reset in the middle of a request
        reg_write(6'h07, 16'h0000);
        pulse_halt(4'b0010);
        check("rst_pre_req", {15'b0, halt_req}, 16'h0001);
        #2;
        dbg_rst = 1'b1;
        #1;
        check("rst_async", {15'b0, halt_req}, 16'h0000);
        tick();
        dbg_rst = 1'b0;
        read_check("rst_seq_after", 6'h07, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
